// File: rtl/hamming_pkg.sv
// Shared widths, data-bit placement and result flags for the Hamming SECDED decoder.
package hamming_pkg;

    typedef struct packed {
        logic corrected;
        logic uncorr;
    } flags_t;

    function automatic int n_of(input int r);
        return 32'sd1 << r;
    endfunction

    function automatic int k_of(input int r);
        return (32'sd1 << r) - r - 32'sd1;
    endfunction

    // Codeword position of data bit idx: the idx-th non-power-of-two index from 3 upward.
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 32'sd0;
        cnt = 32'sd0;
        for (int p = 32'sd3; p < 32'sd64; p++) begin
            if ((p & (p - 32'sd1)) != 32'sd0) begin
                if (cnt == idx) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_secded_dec_syndrome.sv
// Combinational syndrome (XOR of set-bit indices) and overall parity of a codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int R = 4
) (
    input  logic [n_of(R)-1:0] i_code,
    output logic [R-1:0]       o_syn,
    output logic               o_par
);

    localparam int N = n_of(R);

    // Fold every set bit's index into the syndrome; bit0 carries no index weight.
    always_comb begin
        o_syn = {R{1'b0}};
        for (int b = 1; b < N; b++) begin
            if (i_code[b]) begin
                o_syn = o_syn ^ R'(b);
            end else begin
                o_syn = o_syn;
            end
        end
        o_par = ^i_code;
    end

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshakes.
// Optional saturating error counters are built when HAMMING_ERR_CNT_EN is defined.
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter int R     = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [n_of(R)-1:0]   in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [k_of(R)-1:0]   out_data,
    output logic                 out_corrected,
    output logic                 out_uncorr,
    output logic [R-1:0]         out_err_pos,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     cnt_corr,
    output logic [CNT_W-1:0]     cnt_uncorr
);

    localparam int N = n_of(R);
    localparam int K = k_of(R);

    logic [R-1:0]   w_syn;
    logic           w_par;
    logic           w_s1_load;
    logic           w_s2_load;
    logic [N-1:0]   w_fixed;
    logic [K-1:0]   w_data;
    flags_t         w_flags;

    logic           r_s1_valid;
    logic [N-1:0]   r_s1_code;
    logic [R-1:0]   r_s1_syn;
    logic           r_s1_par;

    logic           r_out_valid;
    logic [K-1:0]   r_out_data;
    flags_t         r_out_flags;
    logic [R-1:0]   r_out_err_pos;

    hamming_syndrome #(.R(R)) u_syndrome (
        .i_code (in_code),
        .o_syn  (w_syn),
        .o_par  (w_par)
    );

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // Stage 1: capture the accepted codeword with its syndrome and parity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= {N{1'b0}};
            r_s1_syn   <= {R{1'b0}};
            r_s1_par   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_syn;
                r_s1_par  <= w_par;
            end
        end
    end

    // Odd parity means one flipped bit at the syndrome position (bit0 when syndrome is 0).
    always_comb begin
        w_fixed = r_s1_code;
        if (r_s1_par) begin
            w_fixed[r_s1_syn] = ~r_s1_code[r_s1_syn];
        end else begin
            w_fixed = r_s1_code;
        end
        w_flags.corrected = r_s1_par;
        w_flags.uncorr    = !r_s1_par && (r_s1_syn != {R{1'b0}});
    end

    for (genvar j = 0; j < K; j++) begin : g_data
        assign w_data[j] = w_fixed[data_pos(j)];
    end

    // Stage 2: registered decoded word and flags, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= {K{1'b0}};
            r_out_flags   <= '{corrected: 1'b0, uncorr: 1'b0};
            r_out_err_pos <= {R{1'b0}};
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data    <= w_data;
                r_out_flags   <= w_flags;
                r_out_err_pos <= r_s1_syn;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_corrected = r_out_flags.corrected;
    assign out_uncorr    = r_out_flags.uncorr;
    assign out_err_pos   = r_out_err_pos;

`ifdef HAMMING_ERR_CNT_EN
    logic             w_hs;
    logic [CNT_W-1:0] r_cnt_corr;
    logic [CNT_W-1:0] r_cnt_uncorr;

    assign w_hs = r_out_valid && out_ready;

    // Event counters saturate at all-ones; a clear wins over a same-cycle event.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            r_cnt_corr   <= {CNT_W{1'b0}};
            r_cnt_uncorr <= {CNT_W{1'b0}};
        end else begin
            if (w_hs && r_out_flags.corrected && (r_cnt_corr != {CNT_W{1'b1}})) begin
                r_cnt_corr <= r_cnt_corr + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_hs && r_out_flags.uncorr && (r_cnt_uncorr != {CNT_W{1'b1}})) begin
                r_cnt_uncorr <= r_cnt_uncorr + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign cnt_corr   = r_cnt_corr;
    assign cnt_uncorr = r_cnt_uncorr;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign cnt_corr         = {CNT_W{1'b0}};
    assign cnt_uncorr       = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Self-checking bench for hamming_secded_dec (R=4): directed vectors, stalls, reset flush,
// randomized traffic against a brute-force reference decoder; counter checks when HAMMING_ERR_CNT_EN.
module tb_hamming_secded_dec;

    localparam int TR  = 4;
    localparam int TN  = 16;
    localparam int TK  = 11;
    localparam int TCW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [TN-1:0]   in_code = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [TK-1:0]   out_data;
    logic            out_corrected;
    logic            out_uncorr;
    logic [TR-1:0]   out_err_pos;
    logic            cnt_clr = 1'b0;
    logic [TCW-1:0]  cnt_corr;
    logic [TCW-1:0]  cnt_uncorr;

    hamming_secded_dec #(.R(TR), .CNT_W(TCW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_corrected (out_corrected),
        .out_uncorr    (out_uncorr),
        .out_err_pos   (out_err_pos),
        .cnt_clr       (cnt_clr),
        .cnt_corr      (cnt_corr),
        .cnt_uncorr    (cnt_uncorr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [TK-1:0] data;
        logic          corr;
        logic          uncorr;
        logic [TR-1:0] pos;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // A legal codeword satisfies every Hamming group check and has even overall weight.
    function automatic bit is_cw(input logic [TN-1:0] c);
        bit x;
        for (int i = 0; i < TR; i++) begin
            x = 1'b0;
            for (int p = 1; p < TN; p++)
                if (((p >> i) & 1) == 1) x = x ^ c[p];
            if (x) return 1'b0;
        end
        return (^c) == 1'b0;
    endfunction

    function automatic logic [TK-1:0] extract(input logic [TN-1:0] c);
        logic [TK-1:0] d;
        int idx;
        d = '0;
        idx = 0;
        for (int p = 1; p < TN; p++)
            if (!is_pow2(p)) begin
                d[idx] = c[p];
                idx++;
            end
        return d;
    endfunction

    function automatic logic [TN-1:0] encode(input logic [TK-1:0] d);
        logic [TN-1:0] c;
        int idx;
        bit x;
        c = '0;
        idx = 0;
        for (int p = 1; p < TN; p++)
            if (!is_pow2(p)) begin
                c[p] = d[idx];
                idx++;
            end
        for (int i = 0; i < TR; i++) begin
            x = 1'b0;
            for (int p = 1; p < TN; p++)
                if (((p >> i) & 1) == 1) x = x ^ c[p];
            c[1 << i] = x;
        end
        c[0] = ^c[TN-1:1];
        return c;
    endfunction

    // Reference: a legal word is clean; otherwise search for a single flip that makes it legal.
    function automatic exp_t ref_decode(input logic [TN-1:0] c);
        exp_t e;
        logic [TN-1:0] t;
        int s;
        e.data = extract(c);
        e.corr = 1'b0;
        e.uncorr = 1'b0;
        e.pos = '0;
        if (is_cw(c)) return e;
        for (int b = 0; b < TN; b++) begin
            t = c;
            t[b] = ~t[b];
            if (is_cw(t)) begin
                e.data = extract(t);
                e.corr = 1'b1;
                e.pos = TR'(b);
                return e;
            end
        end
        s = 0;
        for (int p = 1; p < TN; p++)
            if (c[p]) s = s ^ p;
        e.uncorr = 1'b1;
        e.pos = TR'(s);
        return e;
    endfunction

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    bit            stall_prev = 1'b0;
    logic [TK-1:0] sv_data;
    logic          sv_corr;
    logic          sv_uncorr;
    logic [TR-1:0] sv_pos;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(sv_data));
                chk("hold_flags", 64'({out_corrected, out_uncorr}), 64'({sv_corr, sv_uncorr}));
                chk("hold_pos", 64'(out_err_pos), 64'(sv_pos));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.data));
                    chk("sb_corrected", 64'(out_corrected), 64'(e.corr));
                    chk("sb_uncorr", 64'(out_uncorr), 64'(e.uncorr));
                    chk("sb_err_pos", 64'(out_err_pos), 64'(e.pos));
                end
            end
            stall_prev = out_valid && !out_ready;
            sv_data = out_data;
            sv_corr = out_corrected;
            sv_uncorr = out_uncorr;
            sv_pos = out_err_pos;
            if (in_valid && in_ready) q.push_back(ref_decode(in_code));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_word(input string tag, input logic [TN-1:0] code, input logic [TK-1:0] d,
                            input logic c, input logic u, input logic [TR-1:0] pos);
        out_ready = 1'b1;
        in_code = code;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, "_lat2_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(d));
        chk({tag, "_flags"}, 64'({out_corrected, out_uncorr}), 64'({c, u}));
        chk({tag, "_pos"}, 64'(out_err_pos), 64'(pos));
        step();
    endtask

    task automatic push(input logic [TN-1:0] code, input bit rnd_ready);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_code = code;
        for (int t = 0; t < 64 && !acc; t++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_ready;
            step();
        end
        chk("accept_bound", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 32 && q.size() != 0; t++) step();
        step();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TN-1:0] w[4];
        logic [TN-1:0] c;
        int na;
        int b;
        bit acc;

        repeat (3) step();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_flags", 64'({out_corrected, out_uncorr}), 64'd0);
        chk("rst_err_pos", 64'(out_err_pos), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_counters", 64'({cnt_corr, cnt_uncorr}), 64'd0);

        one_word("clean_000f", 16'h000F, 11'h001, 1'b0, 1'b0, 4'd0);
        one_word("single_0008", 16'h0008, 11'h000, 1'b1, 1'b0, 4'd3);
        one_word("single_bit0", 16'h0001, 11'h000, 1'b1, 1'b0, 4'd0);
        one_word("double_0018", 16'h0018, 11'h001, 1'b0, 1'b1, 4'd7);

        // Four back-to-back words against a three-cycle downstream stall.
        for (int i = 0; i < 4; i++) begin
            w[i] = encode(TK'($urandom));
            b = $urandom_range(0, TN - 1);
            w[i][b] = ~w[i][b];
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        na = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            in_code = w[na];
            #1;
            acc = in_ready;
            step();
            if (acc) na++;
        end
        chk("stall_accepts", 64'(na), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_head_data", 64'(out_data), 64'(ref_decode(w[0]).data));
        out_ready = 1'b1;
        for (int t = 0; t < 16 && na < 4; t++) begin
            in_code = w[na];
            #1;
            acc = in_ready;
            step();
            if (acc) na++;
        end
        chk("stall_all_accepted", 64'(na), 64'd4);
        drain();

        // Randomized traffic with 0..2 injected bit errors and random backpressure.
        for (int i = 0; i < 150; i++) begin
            c = encode(TK'($urandom));
            for (int e = 0; e < int'($urandom_range(0, 2)); e++) begin
                b = $urandom_range(0, TN - 1);
                c[b] = ~c[b];
            end
            push(c, 1'b1);
        end
        drain();
`ifndef HAMMING_ERR_CNT_EN
        chk("cnt_tied_zero", 64'({cnt_corr, cnt_uncorr}), 64'd0);
`endif

        // Reset with two words in flight discards them.
        out_ready = 1'b0;
        push(encode(11'h155), 1'b0);
        push(encode(11'h2AA), 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) step();
        chk("flush_no_stale", 64'(out_valid), 64'd0);

`ifdef HAMMING_ERR_CNT_EN
        out_ready = 1'b1;
        for (int i = 0; i < (1 << TCW) - 1; i++) push(16'h0008, 1'b0);
        drain();
        chk("cnt_preload", 64'(cnt_corr), 64'((1 << TCW) - 1));
        push(16'h0001, 1'b0);
        drain();
        chk("cnt_saturate", 64'(cnt_corr), 64'((1 << TCW) - 1));
        push(16'h0018, 1'b0);
        drain();
        chk("cnt_uncorr_one", 64'(cnt_uncorr), 64'd1);
        out_ready = 1'b0;
        push(16'h0008, 1'b0);
        in_valid = 1'b0;
        for (int t = 0; t < 8 && !out_valid; t++) step();
        chk("clr_wait_valid", 64'(out_valid), 64'd1);
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_priority_corr", 64'(cnt_corr), 64'd0);
        chk("clr_priority_uncorr", 64'(cnt_uncorr), 64'd0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
